// File: rtl/uart_dma_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART DMA send port (pass-through, no buffering).
// Define UART_ARB_TIMEOUT_EN to enable the requester-stall abort (PAD then DRAIN).
module uart_dma_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [8*NUM_REQ-1:0] i_req_tdata,
    input  logic [NUM_REQ-1:0]   i_req_tlast,
    input  logic [NUM_REQ-1:0]   i_req_tvalid,
    output logic [NUM_REQ-1:0]   o_req_tready,
    output logic [7:0]           o_uart_DMA_tdata,
    output logic                 o_uart_DMA_tlast,
    output logic                 o_uart_DMA_tvalid,
    input  logic                 i_uart_DMA_tready,
    output logic [ID_W-1:0]      o_grant_id,
    output logic                 o_busy,
    output logic                 o_pkt_done,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1
`ifdef UART_ARB_TIMEOUT_EN
        ,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] w_sel;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_ptr_next;
    logic            w_any;
    logic [7:0]      w_lane_data;
    logic            w_lane_last;
    logic            w_lane_valid;

    assign w_lane_data  = i_req_tdata[{r_grant, 3'b000} +: 8];
    assign w_lane_last  = i_req_tlast[r_grant];
    assign w_lane_valid = i_req_tvalid[r_grant];
    assign w_ptr_next   = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_any        = |i_req_tvalid;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_grant_id   = r_grant;

    // Walk from the highest offset down so the requester closest to r_ptr wins.
    always_comb begin
        w_sel = '0;
        w_sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(i);
            if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
            end
            if (i_req_tvalid[w_sum[ID_W-1:0]]) begin
                w_sel = w_sum[ID_W-1:0];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] r_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall <= '0;
        end else if (r_state == ST_XFER && w_state_next == ST_XFER && !w_lane_valid) begin
            r_stall <= r_stall + 16'd1;
        end else begin
            r_stall <= '0;
        end
    end
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT_CYC);
`endif

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_sel;
            end
            if (o_pkt_done) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next      = r_state;
        o_req_tready      = '0;
        o_uart_DMA_tdata  = 8'h00;
        o_uart_DMA_tlast  = 1'b0;
        o_uart_DMA_tvalid = 1'b0;
        o_pkt_done        = 1'b0;
        o_timeout         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                o_uart_DMA_tdata      = w_lane_data;
                o_uart_DMA_tlast      = w_lane_last;
                o_uart_DMA_tvalid     = w_lane_valid;
                o_req_tready[r_grant] = i_uart_DMA_tready;
                if (w_lane_valid && i_uart_DMA_tready && w_lane_last) begin
                    o_pkt_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!w_lane_valid && r_stall == 16'(TIMEOUT_CYC - 1)) begin
                    o_timeout    = 1'b1;
                    w_state_next = ST_PAD;
                end
`endif
            end
`ifdef UART_ARB_TIMEOUT_EN
            // Close the downstream packet with a zero pad byte before discarding the rest.
            ST_PAD: begin
                o_uart_DMA_tdata  = 8'h00;
                o_uart_DMA_tlast  = 1'b1;
                o_uart_DMA_tvalid = 1'b1;
                if (i_uart_DMA_tready) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_req_tready[r_grant] = 1'b1;
                if (w_lane_valid && w_lane_last) begin
                    o_pkt_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_dma_tx_arbiter.sv
// Directed self-checking bench for uart_dma_tx_arbiter; timeout scenario runs only when
// UART_ARB_TIMEOUT_EN is defined.
module tb_uart_dma_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk        = 1'b0;
    logic                 rst_n      = 1'b0;
    logic [8*NUM_REQ-1:0] req_tdata  = '0;
    logic [NUM_REQ-1:0]   req_tlast  = '0;
    logic [NUM_REQ-1:0]   req_tvalid = '0;
    logic [NUM_REQ-1:0]   req_tready;
    logic [7:0]           dma_tdata;
    logic                 dma_tlast;
    logic                 dma_tvalid;
    logic                 dma_tready = 1'b0;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 pkt_done;
    logic                 timeout;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int first_cyc = -1;
    int n_timeout = 0;
    int guard;

    logic [8:0]         lane_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] en = '1;
    logic [8:0]         out_q[$];
    logic [8:0]         exp_q[$];
    int                 done_grant[$];
    int                 done_cyc[$];
    int                 exp_grant[$];

    uart_dma_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ID_W       (ID_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_tdata      (req_tdata),
        .i_req_tlast      (req_tlast),
        .i_req_tvalid     (req_tvalid),
        .o_req_tready     (req_tready),
        .o_uart_DMA_tdata (dma_tdata),
        .o_uart_DMA_tlast (dma_tlast),
        .o_uart_DMA_tvalid(dma_tvalid),
        .i_uart_DMA_tready(dma_tready),
        .o_grant_id       (grant_id),
        .o_busy           (busy),
        .o_pkt_done       (pkt_done),
        .o_timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present queue heads, sample handshakes before the edge, pop after it.
    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (lane_q[k].size() > 0) begin
                req_tvalid[k]       = en[k];
                req_tlast[k]        = lane_q[k][0][8];
                req_tdata[8*k +: 8] = lane_q[k][0][7:0];
            end else begin
                req_tvalid[k]       = 1'b0;
                req_tlast[k]        = 1'b0;
                req_tdata[8*k +: 8] = 8'h00;
            end
        end
        #1;
        acc = req_tvalid & req_tready;
        if (dma_tvalid && dma_tready) begin
            out_q.push_back({dma_tlast, dma_tdata});
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (pkt_done) begin
            done_grant.push_back(int'(grant_id));
            done_cyc.push_back(cyc);
        end
        if (timeout) n_timeout++;
        @(posedge clk);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc[k]) void'(lane_q[k].pop_front());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_pkt(input int k, input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            lane_q[k].push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic exp_pkt(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic clear_logs();
        out_q.delete();
        exp_q.delete();
        done_grant.delete();
        done_cyc.delete();
        exp_grant.delete();
        cyc       = 0;
        first_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) lane_q[k].delete();
        en         = '1;
        req_tvalid = '0;
        req_tlast  = '0;
        req_tdata  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_done(input int n, input int bound, input string tag);
        guard = 0;
        while (done_grant.size() < n && guard < bound) begin
            tick();
            guard++;
        end
        chk({tag, "_done_seen"}, 32'(done_grant.size()), 32'(n));
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic chk_grants(input string tag);
        chk({tag, "_ngrant"}, 32'(done_grant.size()), 32'(exp_grant.size()));
        for (int i = 0; i < done_grant.size() && i < exp_grant.size(); i++) begin
            chk($sformatf("%s_g%0d", tag, i), 32'(done_grant[i]), 32'(exp_grant[i]));
        end
    endtask

    initial begin
        // Reset state, then an asynchronous reset in the middle of a granted packet.
        dma_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(dma_tvalid), 32'd0);
        chk("rst_tlast", 32'(dma_tlast), 32'd0);
        chk("rst_tdata", 32'(dma_tdata), 32'd0);
        chk("rst_tready", 32'(req_tready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_done", 32'(pkt_done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        lane_q[0].push_back({1'b0, 8'h77});
        lane_q[0].push_back({1'b1, 8'h78});
        tick();
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_tvalid", 32'(dma_tvalid), 32'd1);
        chk("pre_rst_tdata", 32'(dma_tdata), 32'h77);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_tvalid", 32'(dma_tvalid), 32'd0);
        chk("async_rst_tdata", 32'(dma_tdata), 32'd0);
        chk("async_rst_tready", 32'(req_tready), 32'd0);
        do_reset();
        clear_logs();

        // Single 5-byte packet on requester 0.
        lane_q[0].push_back({1'b0, 8'h55});
        lane_q[0].push_back({1'b0, 8'h01});
        lane_q[0].push_back({1'b0, 8'h02});
        lane_q[0].push_back({1'b0, 8'hAA});
        lane_q[0].push_back({1'b1, 8'hBB});
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b1, 8'hBB});
        exp_grant.push_back(0);
        run_until_done(1, 20, "t2");
        chk_out("t2");
        chk_grants("t2");
        chk("t2_first_latency", 32'(first_cyc), 32'd1);
        chk("t2_done_cyc", (done_cyc.size() > 0) ? 32'(done_cyc[0]) : 32'hFFFF_FFFF, 32'd5);
        #1;
        chk("t2_idle_after", 32'(busy), 32'd0);

        // All four requesters competing; reset first so the pointer starts at 0.
        do_reset();
        clear_logs();
        push_pkt(0, 8'h00, 3);
        push_pkt(0, 8'h03, 3);
        push_pkt(1, 8'h10, 3);
        push_pkt(2, 8'h20, 3);
        push_pkt(3, 8'h30, 3);
        exp_pkt(8'h00, 3);
        exp_pkt(8'h10, 3);
        exp_pkt(8'h20, 3);
        exp_pkt(8'h30, 3);
        exp_pkt(8'h03, 3);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        run_until_done(5, 40, "t3");
        chk_out("t3");
        chk_grants("t3");
        for (int i = 0; i < 5 && i < done_cyc.size(); i++) begin
            chk($sformatf("t3_done_cyc%0d", i), 32'(done_cyc[i]), 32'(4 * i + 3));
        end

        // Pointer moved to 2; requesters 1 and 3 valid together -> 3 first.
        clear_logs();
        push_pkt(1, 8'h19, 1);
        run_until_done(1, 10, "t3b_a");
        push_pkt(1, 8'h1A, 2);
        push_pkt(3, 8'h3A, 1);
        exp_pkt(8'h19, 1);
        exp_pkt(8'h3A, 1);
        exp_pkt(8'h1A, 2);
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        run_until_done(3, 20, "t3b");
        chk_out("t3b");
        chk_grants("t3b");

        // Requester 1 with gaps under toggling backpressure while requester 2 waits.
        clear_logs();
        push_pkt(1, 8'hA0, 6);
        tick();
        push_pkt(2, 8'hB0, 2);
        exp_pkt(8'hA0, 6);
        exp_pkt(8'hB0, 2);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        guard = 0;
        while (done_grant.size() < 2 && guard < 100) begin
            dma_tready = (guard % 2 == 0);
            en[1]      = (guard % 3 != 2);
            tick();
            guard++;
        end
        dma_tready = 1'b1;
        en         = '1;
        chk("t4_done_seen", 32'(done_grant.size()), 32'd2);
        chk_out("t4");
        chk_grants("t4");

        // Long downstream stall mid-packet must not abort the transfer.
        clear_logs();
        push_pkt(0, 8'hC0, 3);
        tick();
        tick();
        dma_tready = 1'b0;
        repeat (2000) tick();
        chk("t6_busy_stalled", 32'(busy), 32'd1);
        chk("t6_bytes_stalled", 32'(out_q.size()), 32'd1);
        chk("t6_no_timeout_stall", 32'(n_timeout), 32'd0);
        dma_tready = 1'b1;
        exp_pkt(8'hC0, 3);
        exp_grant.push_back(0);
        run_until_done(1, 10, "t6");
        chk_out("t6");
        chk_grants("t6");
        chk("t6_no_timeout", 32'(n_timeout), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        // Requester 2 stalls after 2 bytes: pad byte, drain, then requester 3.
        clear_logs();
        n_timeout = 0;
        push_pkt(2, 8'hD0, 5);
        push_pkt(3, 8'hE0, 1);
        guard = 0;
        while (out_q.size() < 2 && guard < 10) begin
            tick();
            guard++;
        end
        chk("t5_two_bytes", 32'(out_q.size()), 32'd2);
        en[2] = 1'b0;
        repeat (15) tick();
        chk("t5_no_early_timeout", 32'(n_timeout), 32'd0);
        tick();
        chk("t5_timeout_pulse", 32'(n_timeout), 32'd1);
        chk("t5_pad_tvalid", 32'(dma_tvalid), 32'd1);
        chk("t5_pad_tdata", 32'(dma_tdata), 32'd0);
        chk("t5_pad_tlast", 32'(dma_tlast), 32'd1);
        chk("t5_pad_tready", 32'(req_tready), 32'd0);
        en[2] = 1'b1;
        exp_pkt(8'hD0, 2);
        exp_q[1] = {1'b0, 8'hD1};
        exp_q.push_back({1'b1, 8'h00});
        exp_pkt(8'hE0, 1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        run_until_done(2, 30, "t5");
        chk_out("t5");
        chk_grants("t5");
        chk("t5_drained", 32'(lane_q[2].size()), 32'd0);
        chk("t5_single_timeout", 32'(n_timeout), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
